// File: rtl/ext_aw_arb_pkg.sv
// ---------------------------------------------------------------------------
// ext_aw_arb_pkg
// Shared types and constants for the external AW-channel arbiter.
//   aw_req_t   : one AW request at the default widths (32-bit address,
//                4-bit ID, 6-bit user)
//   state_e    : output-stage state (IDLE: no beat held, VALID: beat held)
//   BURST_INCR : AXI INCR burst encoding driven on master_burst_o
//   idx_w(n)   : width of a requester index for n requesters (minimum 1)
// ---------------------------------------------------------------------------
package ext_aw_arb_pkg;

    localparam int unsigned AW_ADDR_W = 32;
    localparam int unsigned AW_ID_W   = 4;
    localparam int unsigned AW_USER_W = 6;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic [AW_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [AW_ID_W-1:0]   id;
        logic [AW_USER_W-1:0] user;
    } aw_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ext_rr_arb_core.sv
// ---------------------------------------------------------------------------
// ext_rr_arb_core
// Picks one winner out of an eligible vector.
//   Default build           : round-robin; the search starts at an internal
//                             pointer and wraps; after a grant to g the
//                             pointer moves to (g+1) mod N_REQ.
//   EXT_AW_ARB_FIXED_PRIO_EN: fixed priority, lowest eligible index wins;
//                             no pointer register exists.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (pointer only)
//   elig_i        : eligible requesters (already qualified by the caller)
//   grant_o       : one-hot grant, zero when nothing is eligible
//   idx_o         : binary index of the granted requester
//   any_o         : a grant is being issued this cycle
// ---------------------------------------------------------------------------
module ext_rr_arb_core
    import ext_aw_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] elig_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

`ifdef EXT_AW_ARB_FIXED_PRIO_EN

    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk_i, rst_ni};

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
                any_o      = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && elig_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        any_o = found;
    end

    // Pointer moves only on an actual grant; a capped requester that was
    // skipped does not consume its turn.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (32'(idx_o) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/ext_aw_arbiter.sv
// ---------------------------------------------------------------------------
// ext_aw_arbiter
// Shares one external AXI AW channel among N_REQ DMA requesters. Round-robin
// selection, per-requester cap on writes issued without a B response, and a
// registered output stage. The requester index is prepended to the AXI ID so
// the B channel can be routed back.
// Build option: define EXT_AW_ARB_FIXED_PRIO_EN for fixed priority (lowest
// eligible index wins) instead of round-robin.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   req_valid_i        : per-requester AW valid
//   req_addr/len/size/id/user_i : packed per-requester AW fields,
//                        requester i at slice [i*W +: W]
//   req_ready_o        : one-hot acceptance pulse (combinational)
//   master_*_o         : registered AW channel toward the AW buffer stage
//   master_ready_i     : AW ready
//   b_valid_i, b_ready_i, b_id_i : B channel monitor; b_id_i MSBs = requester
//   busy_o             : a beat is held or any requester has writes in flight
// ---------------------------------------------------------------------------
module ext_aw_arbiter
    import ext_aw_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned ID_WIDTH   = 4,
    parameter  int unsigned USER_WIDTH = 6,
    parameter  int unsigned MAX_OUT    = 8,
    localparam int unsigned IDX_W      = idx_w(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_REQ*8-1:0]            req_len_i,
    input  logic [N_REQ*3-1:0]            req_size_i,
    input  logic [N_REQ*ID_WIDTH-1:0]     req_id_i,
    input  logic [N_REQ*USER_WIDTH-1:0]   req_user_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic                          master_valid_o,
    output logic [ADDR_WIDTH-1:0]         master_addr_o,
    output logic [7:0]                    master_len_o,
    output logic [2:0]                    master_size_o,
    output logic [1:0]                    master_burst_o,
    output logic [IDX_W+ID_WIDTH-1:0]     master_id_o,
    output logic [USER_WIDTH-1:0]         master_user_o,
    input  logic                          master_ready_i,
    input  logic                          b_valid_i,
    input  logic                          b_ready_i,
    input  logic [IDX_W+ID_WIDTH-1:0]     b_id_i,
    output logic                          busy_o
);

    localparam logic [7:0] CAP = 8'(MAX_OUT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [ID_WIDTH-1:0]   id;
        logic [USER_WIDTH-1:0] user;
        logic [IDX_W-1:0]      idx;
    } beat_t;

    state_e           state_q, state_d;
    beat_t            beat_q, beat_d;
    logic [7:0]       cnt_q [N_REQ];
    logic [7:0]       cnt_d [N_REQ];

    logic             load;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             b_hit;
    logic [IDX_W-1:0] b_idx;
    logic [N_REQ-1:0] b_dec;
    logic             any_out;

    logic unused_b_id;
    assign unused_b_id = ^b_id_i[ID_WIDTH-1:0];

    // The output register may take a new beat when empty or draining this
    // cycle. Held in reset so no requester sees an acceptance during reset.
    assign load = rst_ni && ((state_q == IDLE) || master_ready_i);

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = load && req_valid_i[i] && (cnt_q[i] < CAP);
        end
    end

    ext_rr_arb_core #(
        .N_REQ (N_REQ)
    ) u_core (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .elig_i  (elig),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign req_ready_o = grant;

    // Output-stage state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = VALID;
            VALID:   if (master_ready_i && !grant_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload capture for the winner
    always_comb begin
        beat_d = beat_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                beat_d.addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                beat_d.len  = req_len_i[i*8 +: 8];
                beat_d.size = req_size_i[i*3 +: 3];
                beat_d.id   = req_id_i[i*ID_WIDTH +: ID_WIDTH];
                beat_d.user = req_user_i[i*USER_WIDTH +: USER_WIDTH];
                beat_d.idx  = grant_idx;
            end
        end
    end

    // Outstanding counters. Index values >= N_REQ match no requester and
    // are dropped. A decrement at zero is ignored rather than wrapping.
    assign b_hit = b_valid_i && b_ready_i;
    assign b_idx = b_id_i[IDX_W+ID_WIDTH-1 -: IDX_W];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            b_dec[i] = b_hit && (b_idx == IDX_W'(i));
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !b_dec[i]) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else if (!grant[i] && b_dec[i] && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        any_out = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cnt_q[i] != 8'd0) any_out = 1'b1;
        end
    end

    assign master_valid_o = (state_q == VALID);
    assign master_addr_o  = beat_q.addr;
    assign master_len_o   = beat_q.len;
    assign master_size_o  = beat_q.size;
    assign master_burst_o = BURST_INCR;
    assign master_id_o    = {beat_q.idx, beat_q.id};
    assign master_user_o  = beat_q.user;
    assign busy_o         = master_valid_o || any_out;

`ifndef SYNTHESIS
    // A B response for a requester with nothing in flight points at an
    // upstream or interconnect bug; the counter itself stays at zero.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < N_REQ; i++) begin
                assert (!(b_dec[i] && !grant[i] && (cnt_q[i] == 8'd0)))
                    else $warning("ext_aw_arbiter: B response for requester %0d with no write in flight", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_aw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_aw_arbiter
// Directed scenarios plus a randomized run for ext_aw_arbiter (N_REQ=4,
// MAX_OUT=2). A behavioural model tracks the pointer, per-requester in-flight
// counts and the held beat; it advances on every clock through tick().
// Honours EXT_AW_ARB_FIXED_PRIO_EN for the expected arbitration order.
// ---------------------------------------------------------------------------
module tb_ext_aw_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 6;
    localparam int MO = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [N*3-1:0]  req_size;
    logic [N*IW-1:0] req_id;
    logic [N*UW-1:0] req_user;
    logic [N-1:0]    req_ready;
    logic            m_valid_o;
    logic [AW-1:0]   m_addr_o;
    logic [7:0]      m_len_o;
    logic [2:0]      m_size_o;
    logic [1:0]      m_burst_o;
    logic [IW+1:0]   m_id_o;
    logic [UW-1:0]   m_user_o;
    logic            m_ready;
    logic            b_valid;
    logic            b_ready;
    logic [IW+1:0]   b_id;
    logic            busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ext_aw_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MAX_OUT(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_size_i(req_size), .req_id_i(req_id), .req_user_i(req_user),
        .req_ready_o(req_ready),
        .master_valid_o(m_valid_o), .master_addr_o(m_addr_o), .master_len_o(m_len_o),
        .master_size_o(m_size_o), .master_burst_o(m_burst_o), .master_id_o(m_id_o),
        .master_user_o(m_user_o), .master_ready_i(m_ready),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int            m_ptr;
    int            m_cnt [N];
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;
    logic [2:0]    m_size;
    logic [IW+1:0] m_id;
    logic [UW-1:0] m_user;

    // Winner for the current inputs, -1 when nothing is accepted.
    function automatic int m_winner();
        int start;
        if (!rst_n) return -1;
        if (m_valid && !m_ready) return -1;
`ifdef EXT_AW_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (req_valid[i] && m_cnt[i] < MO) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready_exp();
        int w;
        w = m_winner();
        return (w < 0) ? '0 : N'(1 << w);
    endfunction

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) b = 1'b1;
        return b;
    endfunction

    // Advance one clock: sample inputs, update model at the edge, return on
    // the falling edge so the caller can drive the next cycle.
    task automatic tick();
        int w;
        bit bh, ld;
        int bi;
        w  = m_winner();
        ld = !m_valid || m_ready;
        bh = b_valid && b_ready;
        bi = int'(b_id[IW+1:IW]);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_ptr = 0;
            m_addr = '0; m_len = '0; m_size = '0; m_id = '0; m_user = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (ld) begin
                m_valid = (w >= 0);
                if (w >= 0) begin
                    m_addr = req_addr[w*AW +: AW];
                    m_len  = req_len[w*8 +: 8];
                    m_size = req_size[w*3 +: 3];
                    m_id   = {2'(w), req_id[w*IW +: IW]};
                    m_user = req_user[w*UW +: UW];
                    m_ptr  = (w + 1) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                bit inc, dec;
                inc = (w == i);
                dec = bh && (bi == i);
                if (inc && !dec) m_cnt[i]++;
                else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [IW-1:0] id, input logic [UW-1:0] u);
        req_addr[i*AW +: AW] = a;
        req_len[i*8 +: 8]    = l;
        req_size[i*3 +: 3]   = s;
        req_id[i*IW +: IW]   = id;
        req_user[i*UW +: UW] = u;
    endtask

    // Return all in-flight writes so the next scenario starts from zero.
    task automatic drain_b();
        req_valid = '0;
        m_ready   = 1'b1;
        for (int i = 0; i < N; i++) begin
            while (m_cnt[i] > 0) begin
                b_valid = 1'b1; b_ready = 1'b1; b_id = {2'(i), 4'h5};
                tick();
            end
        end
        b_valid = 1'b0; b_ready = 1'b0; b_id = '0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_during: got %b exp 0000", req_ready); end
        tick(); tick();
        rst_n = 1'b1; req_valid = '0;
        #1;
        n_cmp++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", m_valid_o); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_cmp++; if (m_addr_o !== 32'h0 || m_id_o !== 6'h0 || m_len_o !== 8'h0) begin
            n_fail++; $display("FAIL rst_payload: got addr %h id %h len %h exp zeros", m_addr_o, m_id_o, m_len_o); end
        n_cmp++; if (m_burst_o !== 2'b01) begin n_fail++; $display("FAIL rst_burst: got %b exp 01", m_burst_o); end
        tick();
    endtask

    task automatic test_simultaneous();
        int g [3] = '{0, 1, 2};
        for (int i = 0; i < N; i++) set_req(i, 32'hA000_0000 + 32'(i * 16), 8'(i), 3'd2, 4'(i + 1), 6'(i));
        req_valid = 4'b0111; m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'(1 << g[c])) begin n_fail++; $display("FAIL sim_grant%0d: got %b exp %b", c, req_ready, 4'(1 << g[c])); end
            if (c > 0) begin
                n_cmp++; if (m_valid_o !== 1'b1 || m_id_o[5:4] !== 2'(g[c-1])) begin
                    n_fail++; $display("FAIL sim_out%0d: got valid %b idx %0d exp 1 %0d", c, m_valid_o, m_id_o[5:4], g[c-1]); end
            end
            tick();
            req_valid[g[c]] = 1'b0;
        end
        #1;
        n_cmp++; if (m_valid_o !== 1'b1 || m_id_o !== {2'd2, 4'd3} || m_addr_o !== 32'hA000_0020) begin
            n_fail++; $display("FAIL sim_last: got valid %b id %h addr %h exp 1 23 a0000020", m_valid_o, m_id_o, m_addr_o); end
        tick();
        #1;
        n_cmp++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL sim_drop: got %b exp 0", m_valid_o); end
        drain_b();
    endtask

    task automatic test_stall_hold();
        set_req(3, 32'h1000_0040, 8'd7, 3'd3, 4'h9, 6'h2a);
        set_req(1, 32'h2222_0000, 8'd1, 3'd2, 4'h4, 6'h11);
        req_valid = 4'b1000; m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL hold_grant3: got %b exp 1000", req_ready); end
        tick();
        req_valid = 4'b0010; m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_cmp++; if (m_valid_o !== 1'b1 || m_addr_o !== 32'h1000_0040 || m_len_o !== 8'd7 ||
                         m_id_o !== {2'd3, 4'h9} || m_user_o !== 6'h2a || req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL hold_cyc%0d: got v%b a%h l%0d id%h u%h r%b exp v1 a10000040 l7 id39 u2a r0000",
                                   s, m_valid_o, m_addr_o, m_len_o, m_id_o, m_user_o, req_ready); end
            tick();
        end
        m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_handshake: got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_cmp++; if (m_valid_o !== 1'b1 || m_id_o !== {2'd1, 4'h4} || m_addr_o !== 32'h2222_0000) begin
            n_fail++; $display("FAIL hold_next: got v%b id%h a%h exp v1 id14 a22220000", m_valid_o, m_id_o, m_addr_o); end
        tick();
        drain_b();
    endtask

    task automatic test_cap();
        req_valid = 4'b0010; m_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cap_issue%0d: got %b exp 0010", c, req_ready); end
            tick();
        end
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL cap_blocked: got %b exp 0000", req_ready); end
        tick();
        req_valid = 4'b0110;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL cap_other: got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0010;
        b_valid = 1'b1; b_ready = 1'b1; b_id = {2'd1, 4'hA};
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL cap_b_cycle: got %b exp 0000", req_ready); end
        tick();
        b_valid = 1'b0; b_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cap_after_b: got %b exp 0010", req_ready); end
        tick();
        drain_b();
    endtask

    task automatic test_same_cycle();
        req_valid = 4'b0001; m_ready = 1'b1;
        tick();                                   // count 0 -> 1
        b_valid = 1'b1; b_ready = 1'b1; b_id = {2'd0, 4'h0};
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL same_grant: got %b exp 0001", req_ready); end
        tick();                                   // +1 and -1: stays 1
        b_valid = 1'b0; b_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL same_room: got %b exp 0001", req_ready); end
        tick();                                   // 1 -> 2
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL same_capped: got %b exp 0000", req_ready); end
        tick();
        drain_b();
    endtask

    task automatic test_stray_b();
        tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_pre_busy: got %b exp 0", busy); end
        b_valid = 1'b1; b_ready = 1'b1; b_id = {2'd3, 4'h0};
        tick();
        b_valid = 1'b0; b_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b exp 0", busy); end
        req_valid = 4'b1000; m_ready = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stray_cap: got %b exp 0000", req_ready); end
        tick();
        drain_b();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0001; m_ready = 1'b1;
        tick(); tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0; m_ready = 1'b0;
        #1;
        n_cmp++; if (m_valid_o !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got valid %b busy %b exp 1 1", m_valid_o, busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (m_valid_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_post: got valid %b busy %b exp 0 0", m_valid_o, busy); end
        req_valid = 4'b1111; m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first: got %b exp 0001", req_ready); end
        tick();
        drain_b();
    endtask

    task automatic test_priority();
        logic [N-1:0] exp_g [3];
`ifdef EXT_AW_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0100, 4'b0001};
`endif
        rst_n = 1'b0; req_valid = '0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0101; m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            b_valid = (c > 0); b_ready = (c > 0); b_id = {2'd0, 4'h1};
            #1;
            n_cmp++; if (req_ready !== exp_g[c]) begin n_fail++; $display("FAIL prio_%0d: got %b exp %b", c, req_ready, exp_g[c]); end
            tick();
        end
        b_valid = 1'b0; b_ready = 1'b0;
        drain_b();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int bi;
            req_valid = 4'($urandom);
            m_ready   = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) set_req(i, $urandom, 8'($urandom), 3'($urandom), 4'($urandom), 6'($urandom));
            bi = $urandom_range(0, N - 1);
            b_valid = (m_cnt[bi] > 0) && ($urandom_range(0, 1) == 1);
            b_ready = ($urandom_range(0, 3) != 0);
            b_id    = {2'(bi), 4'($urandom)};
            #1;
            n_cmp++; if (req_ready !== m_ready_exp()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, req_ready, m_ready_exp()); end
            n_cmp++; if (m_valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", c, m_valid_o, m_valid); end
            if (m_valid) begin
                n_cmp++; if (m_addr_o !== m_addr || m_len_o !== m_len || m_size_o !== m_size ||
                             m_id_o !== m_id || m_user_o !== m_user || m_burst_o !== 2'b01) begin
                    n_fail++; $display("FAIL rnd_beat@%0d: got a%h l%h s%h id%h u%h exp a%h l%h s%h id%h u%h",
                                       c, m_addr_o, m_len_o, m_size_o, m_id_o, m_user_o, m_addr, m_len, m_size, m_id, m_user); end
            end
            n_cmp++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, busy, m_busy()); end
            tick();
        end
        b_valid = 1'b0; b_ready = 1'b0;
        drain_b();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
        req_id = '0; req_user = '0; m_ready = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_id = '0;
        m_ptr = 0; m_valid = 0; m_addr = '0; m_len = '0; m_size = '0; m_id = '0; m_user = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_simultaneous();
        test_stall_hold();
        test_cap();
        test_same_cycle();
        test_stray_b();
        test_reset_mid();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
